// File: rtl/set_job_host_if.sv
// Handshake bundle for set_job_host: job input stream, SET issue/response, result output.
// The slave modport is the host block itself; master is whoever drives it.
interface set_job_host_if #(
   parameter int unsigned DEPTH = 4
);
   logic                     job_valid;
   logic                     job_ready;
   logic [23:0]              job_central;
   logic [11:0]              job_radius;
   logic [1:0]               job_mode;

   logic                     set_en;
   logic [23:0]              set_central;
   logic [11:0]              set_radius;
   logic [1:0]               set_mode;
   logic                     set_busy;
   logic                     set_valid;
   logic [7:0]               set_candidate;

   logic                     res_valid;
   logic                     res_ready;
   logic [7:0]               res_candidate;
   logic [3:0]               res_seq;
   logic                     res_err;

   logic [$clog2(DEPTH):0]   fifo_count;

   modport master (
      output job_valid, job_central, job_radius, job_mode,
      output set_busy, set_valid, set_candidate,
      output res_ready,
      input  job_ready, set_en, set_central, set_radius, set_mode,
      input  res_valid, res_candidate, res_seq, res_err, fifo_count
   );

   modport slave (
      input  job_valid, job_central, job_radius, job_mode,
      input  set_busy, set_valid, set_candidate,
      input  res_ready,
      output job_ready, set_en, set_central, set_radius, set_mode,
      output res_valid, res_candidate, res_seq, res_err, fifo_count
   );
endinterface

// File: rtl/set_job_host.sv
// Host driver for the SET engine: job FIFO, one-job-at-a-time issue, result capture.
// Optional WAIT watchdog enabled by defining SET_HOST_TIMEOUT_EN.
module set_job_host #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           rst,
   set_job_host_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DepthCount = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
   } job_t;

   job_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   job_t          job_in;

   state_e        state_q;
   logic          set_en_q;
   job_t          set_job_q;
   logic          res_valid_q;
   logic [7:0]    res_cand_q;
   logic [3:0]    res_seq_q;

   assign full   = (count_q == DepthCount);
   assign empty  = (count_q == '0);
   assign job_in = {bus.job_central, bus.job_radius, bus.job_mode};
   // Ready depends only on the registered count, never on a same-cycle pop.
   assign push   = bus.job_valid && !full;
   assign pop    = (state_q == StIdle) && !empty && !bus.set_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[AW'(i)] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= job_in;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

`ifdef SET_HOST_TIMEOUT_EN
   localparam logic [15:0] WdogLimit = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wdog_q;
   logic        res_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         set_en_q    <= 1'b0;
         set_job_q   <= '0;
         res_valid_q <= 1'b0;
         res_cand_q  <= '0;
         res_seq_q   <= '0;
         res_err_q   <= 1'b0;
         wdog_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  set_job_q <= mem_q[rd_ptr_q];
                  set_en_q  <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               set_en_q <= 1'b0;
               wdog_q   <= '0;
               state_q  <= StWait;
            end
            StWait: begin
               // A real response on the limit cycle takes priority over the timeout.
               if (bus.set_valid) begin
                  res_cand_q  <= bus.set_candidate;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else if (wdog_q == WdogLimit) begin
                  res_cand_q  <= 8'hFF;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            StDone: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  res_seq_q   <= res_seq_q + 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.res_err = res_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         set_en_q    <= 1'b0;
         set_job_q   <= '0;
         res_valid_q <= 1'b0;
         res_cand_q  <= '0;
         res_seq_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  set_job_q <= mem_q[rd_ptr_q];
                  set_en_q  <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               set_en_q <= 1'b0;
               state_q  <= StWait;
            end
            StWait: begin
               if (bus.set_valid) begin
                  res_cand_q  <= bus.set_candidate;
                  res_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  res_seq_q   <= res_seq_q + 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.res_err = 1'b0;
`endif

   assign bus.job_ready     = !full;
   assign bus.set_en        = set_en_q;
   assign bus.set_central   = set_job_q.central;
   assign bus.set_radius    = set_job_q.radius;
   assign bus.set_mode      = set_job_q.mode;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_candidate = res_cand_q;
   assign bus.res_seq       = res_seq_q;
   assign bus.fifo_count    = count_q;

endmodule

// File: tb/tb_set_job_host.sv
// Bench for set_job_host: directed vector table, hand sequences and random traffic
// checked against a transaction-level queue model with a simple SET responder.
module tb_set_job_host;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 20;

   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
   } job_t;

   typedef struct packed {
      logic       jv;
      logic       rr;
      logic       busy;
      logic       sv;
      logic [7:0] cand;
      logic       jr;
      logic       en;
      logic       rv;
      logic [7:0] rc;
      logic [3:0] rs;
      logic [2:0] fc;
      logic       chk_job;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   set_job_host_if #(.DEPTH(DEPTH)) bus ();

   set_job_host #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Transaction model
   job_t       m_q[$];
   job_t       m_cur;
   bit         m_inflight;
   bit         m_have_res;
   int         m_age;
   logic [7:0] m_res_cand;
   logic       m_res_err;
   logic [3:0] m_seq;

   // SET responder
   bit         stub_active;
   bit         stub_busy;
   bit         stub_hold;
   bit         busy_force;
   int         stub_cnt;
   int         stub_lat = 2;
   logic [7:0] stub_cand;

   bit         last_push;
   bit         last_issue;
   bit         last_accept;
   logic [3:0] last_acc_seq;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " job_ready"}, bus.job_ready, 1);
      chk({tag, " set_en"}, bus.set_en, 0);
      chk({tag, " set_central"}, bus.set_central, 0);
      chk({tag, " set_radius"}, bus.set_radius, 0);
      chk({tag, " set_mode"}, bus.set_mode, 0);
      chk({tag, " res_valid"}, bus.res_valid, 0);
      chk({tag, " res_candidate"}, bus.res_candidate, 0);
      chk({tag, " res_seq"}, bus.res_seq, 0);
      chk({tag, " res_err"}, bus.res_err, 0);
      chk({tag, " fifo_count"}, bus.fifo_count, 0);
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check_reset_vals(tag);
      bus.job_valid     = 1'b0;
      bus.res_ready     = 1'b0;
      bus.set_valid     = 1'b0;
      bus.set_busy      = 1'b0;
      bus.set_candidate = 8'h00;
      stub_active = 0;
      stub_busy   = 0;
      stub_hold   = 0;
      busy_force  = 0;
      m_q.delete();
      m_inflight = 0;
      m_have_res = 0;
      m_age      = 0;
      m_seq      = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic new_job();
      bus.job_central = 24'($urandom);
      bus.job_radius  = 12'($urandom);
      bus.job_mode    = 2'($urandom);
   endtask

   // One clock: predict from the rules, advance, compare, then let SET respond.
   task automatic step();
      job_t       job_in;
      logic       push, issue, accept, got_res, tmo;
      logic [7:0] cand_in;
      job_in = {bus.job_central, bus.job_radius, bus.job_mode};
      chk("job_ready", bus.job_ready, (m_q.size() != int'(DEPTH)));
      push    = bus.job_valid && (m_q.size() != int'(DEPTH));
      issue   = !m_inflight && (m_q.size() != 0) && !bus.set_busy;
      accept  = m_have_res && bus.res_ready;
      got_res = 1'b0;
      tmo     = 1'b0;
      if (m_inflight && !m_have_res) begin
         if (m_age >= 1 && bus.set_valid) got_res = 1'b1;
`ifdef SET_HOST_TIMEOUT_EN
         else if (m_age == int'(TMO)) tmo = 1'b1;
`endif
      end
      cand_in      = bus.set_candidate;
      last_acc_seq = bus.res_seq;
      @(posedge clk);
      #1;
      if (m_inflight && !m_have_res) m_age++;
      if (got_res) begin
         m_have_res = 1;
         m_res_cand = cand_in;
         m_res_err  = 1'b0;
      end
      if (tmo) begin
         m_have_res = 1;
         m_res_cand = 8'hFF;
         m_res_err  = 1'b1;
      end
      if (accept) begin
         m_have_res = 0;
         m_inflight = 0;
         m_seq      = m_seq + 4'd1;
      end
      if (issue) begin
         m_cur      = m_q.pop_front();
         m_inflight = 1;
         m_age      = 0;
      end
      if (push) m_q.push_back(job_in);
      last_push   = push;
      last_issue  = issue;
      last_accept = accept;
      chk("set_en", bus.set_en, issue);
      chk("fifo_count", bus.fifo_count, m_q.size());
      chk("res_valid", bus.res_valid, m_have_res);
      chk("res_seq", bus.res_seq, m_seq);
      if (m_have_res) begin
         chk("res_candidate", bus.res_candidate, m_res_cand);
         chk("res_err", bus.res_err, m_res_err);
      end
      if (m_inflight) begin
         chk("set_central", bus.set_central, m_cur.central);
         chk("set_radius", bus.set_radius, m_cur.radius);
         chk("set_mode", bus.set_mode, m_cur.mode);
      end
      if (bus.set_valid) begin
         bus.set_valid = 1'b0;
         stub_busy     = 0;
         stub_active   = 0;
      end else if (stub_active && !stub_hold) begin
         stub_cnt--;
         if (stub_cnt == 0) begin
            bus.set_valid     = 1'b1;
            bus.set_candidate = stub_cand;
         end
      end
      if (bus.set_en) begin
         stub_active = 1;
         stub_busy   = 1;
         stub_cnt    = stub_lat;
         stub_cand   = bus.set_central[7:0] ^ bus.set_radius[11:4] ^ {6'd0, bus.set_mode};
      end
      bus.set_busy = stub_busy | busy_force;
   endtask

   task automatic drain(input string tag);
      bus.res_ready = 1'b1;
      bus.job_valid = 1'b0;
      for (int c = 0; c < 200 && (m_q.size() != 0 || m_inflight); c++) step();
      chk({tag, " drained"}, (m_q.size() == 0 && !m_inflight), 1);
   endtask

   vec_t tbl [8];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : main
      int pushed, peak, issues, results, cnt;
      bit blocked;

      bus.job_valid     = 1'b0;
      bus.job_central   = '0;
      bus.job_radius    = '0;
      bus.job_mode      = '0;
      bus.res_ready     = 1'b0;
      bus.set_busy      = 1'b0;
      bus.set_valid     = 1'b0;
      bus.set_candidate = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst = 1'b0;

      // Single job, SET responds with 29 two cycles after issue.
      //          jv    rr    busy  sv    cand    jr    en    rv    rc      rs    fc    job
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  4'd0, 3'd1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  4'd0, 3'd0, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  4'd0, 3'd0, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  4'd0, 3'd0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd29, 1'b1, 1'b0, 1'b1, 8'd29, 4'd0, 3'd0, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd29, 4'd0, 3'd0, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  4'd1, 3'd0, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  4'd1, 3'd0, 1'b0};
      bus.job_central = 24'h444444;
      bus.job_radius  = 12'h333;
      bus.job_mode    = 2'd0;
      for (int i = 0; i < 8; i++) begin
         bus.job_valid     = tbl[i].jv;
         bus.res_ready     = tbl[i].rr;
         bus.set_busy      = tbl[i].busy;
         bus.set_valid     = tbl[i].sv;
         bus.set_candidate = tbl[i].cand;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d job_ready", i), bus.job_ready, tbl[i].jr);
         chk($sformatf("vec%0d set_en", i), bus.set_en, tbl[i].en);
         chk($sformatf("vec%0d res_valid", i), bus.res_valid, tbl[i].rv);
         chk($sformatf("vec%0d res_seq", i), bus.res_seq, tbl[i].rs);
         chk($sformatf("vec%0d fifo_count", i), bus.fifo_count, tbl[i].fc);
         if (tbl[i].rv) begin
            chk($sformatf("vec%0d res_candidate", i), bus.res_candidate, tbl[i].rc);
            chk($sformatf("vec%0d res_err", i), bus.res_err, 0);
         end
         if (tbl[i].chk_job) begin
            chk($sformatf("vec%0d set_central", i), bus.set_central, 24'h444444);
            chk($sformatf("vec%0d set_radius", i), bus.set_radius, 12'h333);
            chk($sformatf("vec%0d set_mode", i), bus.set_mode, 2'd0);
         end
      end
      apply_reset("rst1");

      // Back-pressure: six jobs offered back-to-back, results held off.
      stub_lat      = 3;
      bus.res_ready = 1'b0;
      pushed  = 0;
      peak    = 0;
      issues  = 0;
      results = 0;
      blocked = 0;
      new_job();
      bus.job_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (!bus.job_ready) blocked = 1;
         step();
         if (last_issue) issues++;
         if (last_push) begin
            pushed++;
            if (pushed == 6) bus.job_valid = 1'b0;
            else new_job();
         end
         if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
      end
      chk("bp accepted before release", pushed, 5);
      chk("bp fifo peak", peak, 4);
      chk("bp job_ready went low", blocked, 1);
      chk("bp single issue while held", issues, 1);
      bus.res_ready = 1'b1;
      for (int c = 0; c < 200 && results < 6; c++) begin
         step();
         if (last_push) begin
            pushed++;
            if (pushed == 6) bus.job_valid = 1'b0;
            else new_job();
         end
         if (last_accept) begin
            chk($sformatf("bp res_seq order %0d", results), last_acc_seq, results);
            results++;
         end
      end
      chk("bp results", results, 6);
      chk("bp pushed", pushed, 6);
      drain("bp");

      // Busy gating: queued job must wait for set_busy to drop.
      busy_force    = 1;
      bus.set_busy  = 1'b1;
      new_job();
      bus.job_valid = 1'b1;
      step();
      chk("busy job accepted", last_push, 1);
      bus.job_valid = 1'b0;
      issues = 0;
      for (int c = 0; c < 9; c++) begin
         step();
         if (last_issue || bus.set_en) issues++;
      end
      chk("busy no issue", issues, 0);
      busy_force   = 0;
      bus.set_busy = stub_busy;
      step();
      chk("busy release issue", bus.set_en, 1);
      drain("busy");

      // Push and pop on the same edge with two jobs queued.
      bus.res_ready = 1'b0;
      stub_lat      = 2;
      new_job();
      bus.job_valid = 1'b1;
      step();
      bus.job_valid = 1'b0;
      for (int c = 0; c < 20 && !bus.res_valid; c++) step();
      chk("pp reached done", bus.res_valid, 1);
      new_job();
      bus.job_valid = 1'b1;
      step();
      new_job();
      step();
      bus.job_valid = 1'b0;
      chk("pp count before", bus.fifo_count, 2);
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      new_job();
      bus.job_valid = 1'b1;
      step();
      bus.job_valid = 1'b0;
      chk("pp count after push+pop", bus.fifo_count, 2);
      chk("pp issue on push+pop", bus.set_en, 1);
      drain("pp");

      // SET never answers on its own.
      stub_hold     = 1;
      bus.res_ready = 1'b0;
      new_job();
      bus.job_valid = 1'b1;
      step();
      bus.job_valid = 1'b0;
      for (int c = 0; c < 10 && !last_issue; c++) step();
      chk("tmo issued", last_issue, 1);
      cnt = 0;
      for (int c = 0; c < 60 && !bus.res_valid; c++) begin
         step();
         cnt++;
      end
`ifdef SET_HOST_TIMEOUT_EN
      chk("tmo cycles after set_en", cnt, 21);
      chk("tmo candidate", bus.res_candidate, 8'hFF);
      chk("tmo err", bus.res_err, 1);
      stub_active       = 0;
      bus.set_valid     = 1'b1;
      bus.set_candidate = 8'h5A;
      step();
      chk("tmo late valid ignored", bus.res_candidate, 8'hFF);
`else
      chk("no-tmo still waiting", bus.res_valid, 0);
      chk("no-tmo err", bus.res_err, 0);
      stub_active       = 0;
      bus.set_valid     = 1'b1;
      bus.set_candidate = 8'h5A;
      step();
      chk("no-tmo late result valid", bus.res_valid, 1);
      chk("no-tmo late result cand", bus.res_candidate, 8'h5A);
`endif
      stub_hold = 0;
      drain("tmo");

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         if (last_push || !bus.job_valid) begin
            bus.job_valid = ($urandom_range(0, 2) != 0);
            new_job();
         end
         bus.res_ready = 1'($urandom_range(0, 1));
         stub_lat      = int'($urandom_range(1, 8));
         busy_force    = ($urandom_range(0, 9) == 0);
         bus.set_busy  = stub_busy | busy_force;
         if (!bus.set_valid) bus.set_candidate = 8'($urandom);
         step();
      end
      busy_force   = 0;
      bus.set_busy = stub_busy;
      drain("rand");

      // Asynchronous reset while waiting on SET, then a stray set_valid.
      stub_hold = 1;
      new_job();
      bus.job_valid = 1'b1;
      step();
      new_job();
      step();
      bus.job_valid = 1'b0;
      step();
      step();
      #2;
      apply_reset("rst_wait");
      bus.set_valid     = 1'b1;
      bus.set_candidate = 8'h33;
      step();
      chk("post-reset valid ignored", bus.res_valid, 0);
      chk("post-reset no issue", bus.set_en, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
